// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : buffers a valid/ready program stream and replays it into the
//               4-bit core's program port (PC clear, write burst, launch).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module prog_loader #(
  parameter int ADDR_W     = 4,
  parameter int LAUNCH_CYC = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       mem_write,
  output logic [3:0] instr,
  output logic [3:0] portin,
  output logic       PC_reset,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LC_W  = $clog2(LAUNCH_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_CLR    = 3'd2,
    S_BURST  = 3'd3,
    S_LAUNCH = 3'd4,
    S_RUN    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LC_W-1:0]     lcnt_q, lcnt_d;
  logic                overflow_q, overflow_d;
  logic                mem_write_q, mem_write_d;
  logic                pc_reset_q, pc_reset_d;
  logic [3:0]          instr_q, instr_d;
  logic [3:0]          portin_q, portin_d;
  logic [7:0]          prog_mem_q [DEPTH];
  logic                xfer;

  assign in_ready  = (state_q == S_FILL) && (wr_cnt_q < (ADDR_W+1)'(DEPTH));
  assign xfer      = in_valid && in_ready;
  assign busy      = (state_q == S_FILL) || (state_q == S_CLR) ||
                     (state_q == S_BURST) || (state_q == S_LAUNCH);
  assign done      = (state_q == S_RUN);
  assign overflow  = overflow_q;
  assign mem_write = mem_write_q;
  assign PC_reset  = pc_reset_q;
  assign instr     = instr_q;
  assign portin    = portin_q;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    lcnt_d      = lcnt_q;
    overflow_d  = overflow_q;
    instr_d     = instr_q;
    portin_d    = portin_q;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          state_d    = S_FILL;
          wr_cnt_d   = '0;
          overflow_d = 1'b0;
        end
      end
      S_FILL: begin
        if (xfer) begin
          wr_cnt_d = wr_cnt_q + (ADDR_W+1)'(1);
          if (in_last) begin
            state_d = S_CLR;
          end else if (wr_cnt_q == (ADDR_W+1)'(DEPTH - 1)) begin
            state_d    = S_CLR;
            overflow_d = 1'b1;
          end
        end
      end
      S_CLR: begin
        rd_ptr_d = '0;
        state_d  = S_BURST;
      end
      S_BURST: begin
        if (({1'b0, rd_ptr_q} + (ADDR_W+1)'(1)) == wr_cnt_q) begin
          state_d = S_LAUNCH;
          lcnt_d  = LC_W'(1);
        end else begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
      end
      S_LAUNCH: begin
        if (lcnt_q == LC_W'(LAUNCH_CYC)) begin
          state_d = S_RUN;
        end else begin
          lcnt_d = lcnt_q + LC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Core strobes are registered images of the next state, so they line up
    // with the state they belong to and never glitch toward the core.
    pc_reset_d  = (state_d == S_CLR) || (state_d == S_LAUNCH);
    mem_write_d = (state_d == S_BURST);
    if (state_d == S_BURST) begin
      instr_d  = prog_mem_q[rd_ptr_d][7:4];
      portin_d = prog_mem_q[rd_ptr_d][3:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      lcnt_q      <= '0;
      overflow_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pc_reset_q  <= 1'b0;
      instr_q     <= '0;
      portin_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      lcnt_q      <= lcnt_d;
      overflow_q  <= overflow_d;
      mem_write_q <= mem_write_d;
      pc_reset_q  <= pc_reset_d;
      instr_q     <= instr_d;
      portin_q    <= portin_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      prog_mem_q[wr_cnt_q[ADDR_W-1:0]] <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader : directed scoreboard bench for prog_loader.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;

  localparam int LAUNCH_CYC = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       mem_write;
  logic [3:0] instr;
  logic [3:0] portin;
  logic       PC_reset;
  logic       busy;
  logic       done;
  logic       overflow;

  prog_loader #(.ADDR_W(4), .LAUNCH_CYC(LAUNCH_CYC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .mem_write(mem_write),
    .instr    (instr),
    .portin   (portin),
    .PC_reset (PC_reset),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc;
    logic       mw;
    logic [3:0] ins;
    logic [3:0] pin;
    logic       launch;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         cmp_cnt = 0;
  int         err_cnt = 0;
  bit         mon_en = 1'b1;
  bit         in_seq = 1'b0;
  logic [7:0] prog [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every cycle a core strobe is up, pop and compare; a quiet cycle
  // between the PC clear and the launch pulse is a burst gap.
  always @(negedge clk) begin
    if (!mon_en || !reset_n) begin
      in_seq = 1'b0;
    end else if (mem_write || PC_reset) begin
      cmp_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL unexpected_strobe: got pc=%0b mw=%0b with empty queue", PC_reset, mem_write);
      end else begin
        mon_e = exp_q.pop_front();
        if (PC_reset !== mon_e.pc || mem_write !== mon_e.mw ||
            (mon_e.mw && ({instr, portin} !== {mon_e.ins, mon_e.pin}))) begin
          err_cnt++;
          $display("FAIL core_event: got pc=%0b mw=%0b word=%h expected pc=%0b mw=%0b word=%h",
                   PC_reset, mem_write, {instr, portin}, mon_e.pc, mon_e.mw, {mon_e.ins, mon_e.pin});
        end
        in_seq = !mon_e.launch;
      end
    end else if (in_seq) begin
      cmp_cnt++;
      err_cnt++;
      in_seq = 1'b0;
      $display("FAIL burst_gap: got idle cycle expected strobe, %0d events pending", exp_q.size());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_expected(input int n);
    exp_q.push_back('{pc: 1'b1, mw: 1'b0, ins: 4'h0, pin: 4'h0, launch: 1'b0});
    for (int i = 0; i < n; i++)
      exp_q.push_back('{pc: 1'b0, mw: 1'b1, ins: prog[i][7:4], pin: prog[i][3:0], launch: 1'b0});
    for (int l = 1; l <= LAUNCH_CYC; l++)
      exp_q.push_back('{pc: 1'b1, mw: 1'b0, ins: 4'h0, pin: 4'h0, launch: (l == LAUNCH_CYC)});
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    int guard;
    bit ok;
    guard = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance of %h", d);
    end
  endtask

  task automatic run_program(input int n, input bit bubbles, input bit use_last, input bit exp_ovf);
    int lat;
    push_expected(n);
    for (int i = 0; i < n; i++) begin
      if (bubbles) repeat ($urandom_range(0, 2)) tick();
      if (bubbles && i == 3) pulse_start();
      send_word(prog[i], use_last && (i == n - 1));
    end
    if (!use_last) chk("in_ready_after_full", in_ready, 0);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    chk("launch_latency", lat, n + 2);
    chk("run_overflow", overflow, exp_ovf);
    chk("run_busy", busy, 0);
    chk("run_in_ready", in_ready, 0);
    chk("run_strobes", {mem_write, PC_reset}, 0);
    chk("hold_word", {instr, portin}, prog[n-1]);
  endtask

  task automatic load_p1();
    prog[0] = 8'h63; prog[1] = 8'h40; prog[2] = 8'h63; prog[3] = 8'h41;
    prog[4] = 8'h50; prog[5] = 8'h80; prog[6] = 8'h51; prog[7] = 8'h00;
    prog[8] = 8'h70; prog[9] = 8'h99;
  endtask

  initial begin
    int mw;
    int g;
    logic [3:0] a;

    #12;
    chk("reset_outputs", {in_ready, mem_write, instr, portin, PC_reset, busy, done, overflow}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Test 1: back-to-back 10-word program
    load_p1();
    pulse_start();
    chk("fill_ready", in_ready, 1);
    run_program(10, 1'b0, 1'b1, 1'b0);

    // Test 2: same program with bubbles and an ignored start in FILL
    pulse_start();
    run_program(10, 1'b1, 1'b1, 1'b0);

    // Test 3: 16 words without in_last
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      prog[i] = {a, ~a};
    end
    pulse_start();
    run_program(16, 1'b0, 1'b0, 1'b1);

    // Test 4: single word, start held high through CLR/BURST/LAUNCH
    prog[0] = 8'h99;
    pulse_start();
    chk("overflow_cleared", overflow, 0);
    push_expected(1);
    send_word(8'h99, 1'b1);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    chk("single_done", done, 1);
    chk("single_hold", {instr, portin}, 8'h99);

    // Test 6: start in RUN reloads
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("reload_done_low", done, 0);
    chk("reload_in_ready", in_ready, 1);
    chk("reload_busy", busy, 1);
    load_p1();
    run_program(10, 1'b0, 1'b1, 1'b0);

    // Test 5: asynchronous reset during burst word 5
    mon_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) send_word(prog[i], i == 9);
    mw = 0;
    g = 0;
    while (mw < 5 && g < 100) begin
      @(negedge clk);
      if (mem_write) mw++;
      g++;
    end
    chk("burst_word5", {mem_write, instr, portin}, {1'b1, 8'h50});
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {in_ready, mem_write, instr, portin, PC_reset, busy, done, overflow}, 0);
    tick();
    chk("reset_held_idle", {busy, done, mem_write, PC_reset}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;
    pulse_start();
    run_program(10, 1'b0, 1'b1, 1'b0);

    repeat (3) tick();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
